gshare_branch_predictor: RTL
============================

Name: gshare_branch_predictor

Overview:
Parametrised successor to the fetch-stage dynamic branch predictor. It combines a gshare-indexed pattern table of 2-bit saturating counters with a tagged, valid-qualified branch target buffer (BTB). A speculative global history register (GHR) is checkpointed per fetch and repaired on mispredict. The block sits in IF: lookup is combinational from PC_curr, and updates arrive from ID one stage later, together with the GHR snapshot that travelled down the pipe.

Parameters:
IDX_W, 4, table index width; 2**IDX_W entries in each table.
HIST_W, 4, GHR width; must be between 1 and IDX_W inclusive.
TAG_W, 4, BTB tag width.
ADDR_W, 16, PC and target width.
CNT_RST, 2'b00, counter reset value (strongly not taken).

Ports:
clk  in  1  clock; all state updates on the posedge.
rst  in  1  synchronous reset, active-high.
enable  in  1  fetch advance; when 0, no speculative GHR shift.
PC_curr  in  ADDR_W  fetch PC.
IF_ID_PC_curr  in  ADDR_W  PC of the branch being resolved in ID.
IF_ID_ghr  in  HIST_W  GHR snapshot captured when that branch was fetched.
IF_ID_prediction  in  2  counter value predicted for that branch.
wen_BHT  in  1  counter update for a resolved branch.
wen_BTB  in  1  BTB write for a resolved taken branch.
actual_taken  in  1  resolved direction.
actual_target  in  ADDR_W  resolved target.
prediction  out  2  counter at the fetch index.
predicted_taken  out  1  prediction[1] & btb_hit.
predicted_target  out  ADDR_W  BTB target on hit; 0 otherwise.
btb_hit  out  1  selected entry is valid and its tag matches.
ghr  out  HIST_W  current GHR, to be pipelined as IF_ID_ghr.
mispredict_cnt  out  16  saturating count of mispredicts.

Behaviour:
- Fetch index: idx_f = PC_curr[IDX_W:1] ^ zero-extended ghr. PC bit 0 is ignored (halfword-aligned fetch).
- Fetch tag: PC_curr[IDX_W+TAG_W:IDX_W+1].
- Lookup is purely combinational with zero latency.
- Update index: idx_u = IF_ID_PC_curr[IDX_W:1] ^ IF_ID_ghr. Update tag is taken from the same bit slice of IF_ID_PC_curr.
- Counter update (wen_BHT): read-modify-write of the internal entry at idx_u, not of IF_ID_prediction.
  - Taken: +1, saturating at 11.
  - Not taken: -1, saturating at 00.
- BTB write (wen_BTB & actual_taken): the entry at idx_u becomes {valid=1, tag_u, actual_target}.
- wen_BTB with actual_taken=0 has no effect.
- Entries are never invalidated except by reset.
- Mispredict = wen_BHT & (IF_ID_prediction[1] != actual_taken).
- GHR next-state, in priority order:
  1. rst: 0.
  2. Mispredict: {IF_ID_ghr[HIST_W-2:0], actual_taken}, overriding any same-cycle speculative shift.
  3. enable & btb_hit: {ghr[HIST_W-2:0], predicted_taken}.
  4. Otherwise: hold.
  - For HIST_W=1, the shifted value is just the new bit.
- mispredict_cnt increments on each mispredict and saturates at 16'hFFFF.
- Same-cycle read/write to the same index: lookup returns the pre-write value; the write is visible on the next cycle.
- A simultaneous counter update and BTB write to the same idx_u are independent and both take effect.
- Reset (synchronous, wins over every write):
  - All counters become CNT_RST and all valid bits 0; BTB target bits are don't-care.
  - ghr = 0 and mispredict_cnt = 0.
  - Consequently prediction = CNT_RST, btb_hit = 0, predicted_taken = 0, predicted_target = 0.
  - Asserting rst mid-operation discards any pending update in that cycle.

Decomposition:
- Package bp_pkg holds:
  - counter typedef and named encodings SNT=00, WNT=01, WT=10, ST=11;
  - saturating increment/decrement functions;
  - BTB entry struct {valid, tag, target}, sized from the parameters.
- One sub-module, bp_table: parametrised width/depth RAM with one async read port, one sync write port and synchronous reset, instantiated once per table. A second read port on the counter table serves the update read-modify-write.

Test Plan:
- Reset, then PC_curr=0x0006 -> prediction=00, btb_hit=0, predicted_taken=0, predicted_target=0x0000, ghr=0, mispredict_cnt=0.
- wen_BTB=1, actual_taken=1, IF_ID_PC_curr=0x0006, IF_ID_ghr=0, actual_target=0x0040; next cycle lookup PC 0x0006 with ghr=0 -> btb_hit=1, predicted_target=0x0040, predicted_taken=0 because the counter is still 00.
- Four wen_BHT taken updates at idx 3, then one not-taken -> mem[3] sequence 01,10,11,11,10.
- Counter at idx 3 = 11, PC_curr=0x0026 (same index, tag 1 vs stored 0) -> btb_hit=0, predicted_taken=0, predicted_target=0, no GHR shift.
- Same cycle: enable=1 with a BTB hit, plus a mispredict with IF_ID_ghr=4'b1010 and actual_taken=1 -> ghr=4'b0101 and mispredict_cnt+1. Preload the count to 0xFFFF and mispredict again -> count stays 0xFFFF.
- Mid-run rst together with wen_BTB=1 -> write dropped, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor: 2-bit counter
// encodings, saturating counter arithmetic and the default BTB entry layout.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  localparam int BP_TAG_W  = 4;
  localparam int BP_ADDR_W = 16;

  // BTB entry at the default configuration; the top rebuilds the same layout
  // from its own parameters so non-default sizes stay consistent.
  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_ADDR_W-1:0] target;
  } btb_entry_t;

  function automatic cnt_t sat_inc(cnt_t c);
    return (c == ST) ? ST : cnt_t'(c + 2'd1);
  endfunction

  function automatic cnt_t sat_dec(cnt_t c);
    return (c == SNT) ? SNT : cnt_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Fetch lookup / ID update bundle between the pipeline and the predictor.
interface gshare_branch_predictor_if #(
  parameter int HIST_W = 4,
  parameter int ADDR_W = 16
);
  logic              enable;
  logic [ADDR_W-1:0] PC_curr;
  logic [ADDR_W-1:0] IF_ID_PC_curr;
  logic [HIST_W-1:0] IF_ID_ghr;
  logic [1:0]        IF_ID_prediction;
  logic              wen_BHT;
  logic              wen_BTB;
  logic              actual_taken;
  logic [ADDR_W-1:0] actual_target;
  logic [1:0]        prediction;
  logic              predicted_taken;
  logic [ADDR_W-1:0] predicted_target;
  logic              btb_hit;
  logic [HIST_W-1:0] ghr;
  logic [15:0]       mispredict_cnt;

  modport master (
    output enable, PC_curr, IF_ID_PC_curr, IF_ID_ghr, IF_ID_prediction,
           wen_BHT, wen_BTB, actual_taken, actual_target,
    input  prediction, predicted_taken, predicted_target, btb_hit, ghr,
           mispredict_cnt
  );

  modport slave (
    input  enable, PC_curr, IF_ID_PC_curr, IF_ID_ghr, IF_ID_prediction,
           wen_BHT, wen_BTB, actual_taken, actual_target,
    output prediction, predicted_taken, predicted_target, btb_hit, ghr,
           mispredict_cnt
  );
endinterface

// File: rtl/bp_table.sv
// Small register-file RAM: N_RD async read ports, one sync write port,
// synchronous reset of every word to RST_VAL.
module bp_table #(
  parameter int             W       = 2,
  parameter int             DEPTH_W = 4,
  parameter int             N_RD    = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_RD-1:0][DEPTH_W-1:0]    raddr,
  output logic [N_RD-1:0][W-1:0]          rdata,
  input  logic                            we,
  input  logic [DEPTH_W-1:0]              waddr,
  input  logic [W-1:0]                    wdata
);
  logic [W-1:0] mem [2**DEPTH_W];

  // Reset clears the whole array and outranks any write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**DEPTH_W; i++) mem[i] <= RST_VAL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar r = 0; r < N_RD; r++) begin : g_rd
    assign rdata[r] = mem[raddr[r]];
  end
endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage gshare predictor: PC^GHR indexed 2-bit counters plus a tagged
// BTB. Lookup is combinational; updates from ID land on the next posedge.
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int         IDX_W   = 4,
  parameter int         HIST_W  = 4,
  parameter int         TAG_W   = 4,
  parameter int         ADDR_W  = 16,
  parameter logic [1:0] CNT_RST = 2'b00
) (
  input logic                   clk,
  input logic                   rst,
  gshare_branch_predictor_if.slave bp
);
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
  } btb_ent_t;
  localparam int BTB_W = $bits(btb_ent_t);

  logic [HIST_W-1:0] ghr_q, ghr_nxt;
  logic [15:0]       mcnt_q;

  logic [IDX_W-1:0]  idx_f, idx_u;
  logic [TAG_W-1:0]  tag_f, tag_u;
  logic [1:0][1:0]   cnt_rd;
  logic [0:0][BTB_W-1:0] btb_rd;
  btb_ent_t          ent_f, ent_w;
  cnt_t              cnt_u, cnt_nxt;
  logic              hit, mispredict;

  // Shift one outcome into a history; truncation drops the oldest bit and
  // degenerates to just the new bit when HIST_W is 1.
  function automatic logic [HIST_W-1:0] shift_in(logic [HIST_W-1:0] h, logic b);
    return HIST_W'({h, b});
  endfunction

  assign idx_f = bp.PC_curr[IDX_W:1] ^ IDX_W'(ghr_q);
  assign tag_f = bp.PC_curr[IDX_W+TAG_W:IDX_W+1];
  assign idx_u = bp.IF_ID_PC_curr[IDX_W:1] ^ IDX_W'(bp.IF_ID_ghr);
  assign tag_u = bp.IF_ID_PC_curr[IDX_W+TAG_W:IDX_W+1];

  // Port 0 serves fetch, port 1 reads the live counter for the update RMW.
  bp_table #(.W(2), .DEPTH_W(IDX_W), .N_RD(2), .RST_VAL(CNT_RST)) u_bht (
    .clk(clk), .rst(rst), .raddr({idx_u, idx_f}), .rdata(cnt_rd),
    .we(bp.wen_BHT), .waddr(idx_u), .wdata(cnt_nxt)
  );

  bp_table #(.W(BTB_W), .DEPTH_W(IDX_W), .N_RD(1), .RST_VAL('0)) u_btb (
    .clk(clk), .rst(rst), .raddr(idx_f), .rdata(btb_rd),
    .we(bp.wen_BTB & bp.actual_taken), .waddr(idx_u), .wdata(ent_w)
  );

  assign ent_f   = btb_ent_t'(btb_rd[0]);
  assign ent_w   = '{valid: 1'b1, tag: tag_u, target: bp.actual_target};
  assign cnt_u   = cnt_t'(cnt_rd[1]);
  assign cnt_nxt = bp.actual_taken ? sat_inc(cnt_u) : sat_dec(cnt_u);

  assign hit                  = ent_f.valid && (ent_f.tag == tag_f);
  assign bp.btb_hit           = hit;
  assign bp.prediction        = cnt_rd[0];
  assign bp.predicted_taken   = cnt_rd[0][1] & hit;
  assign bp.predicted_target  = hit ? ent_f.target : '0;
  assign bp.ghr               = ghr_q;
  assign bp.mispredict_cnt    = mcnt_q;

  assign mispredict = bp.wen_BHT & (bp.IF_ID_prediction[1] != bp.actual_taken);

  // Repair from the ID snapshot beats the speculative fetch shift.
  always_comb begin
    ghr_nxt = ghr_q;
    if (mispredict)
      ghr_nxt = shift_in(bp.IF_ID_ghr, bp.actual_taken);
    else if (bp.enable && hit)
      ghr_nxt = shift_in(ghr_q, bp.predicted_taken);
  end

  // History register and saturating mispredict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q  <= '0;
      mcnt_q <= '0;
    end else begin
      ghr_q <= ghr_nxt;
      if (mispredict && mcnt_q != 16'hFFFF) mcnt_q <= mcnt_q + 16'd1;
    end
  end

  // PC bits outside the index/tag fields carry no information here.
  logic unused_pc;
  assign unused_pc = ^{bp.PC_curr[ADDR_W-1:IDX_W+TAG_W+1], bp.PC_curr[0],
                       bp.IF_ID_PC_curr[ADDR_W-1:IDX_W+TAG_W+1],
                       bp.IF_ID_PC_curr[0], bp.IF_ID_prediction[0]};
endmodule
